dmem_bytelane_ctrl: RTL and testbench
=====================================

Name: dmem_bytelane_ctrl

Overview:
- Parametrised successor to the single-cycle word data memory used by the MIPS datapath.
- Adds byte and halfword stores with per-lane write enables.
- Adds sign- and zero-extending sub-word loads.
- Adds alignment and range checking.
- Adds a valid/ready request interface with a configurable number of wait states, so slower memory timing can be modelled.
- Sits between the MEM stage (or a multicycle controller) and the data array.

Parameters:
- DEPTH, 256, number of 32-bit words (power of 2, 4..4096).
- LATENCY, 1, wait cycles between request accept and access (0..7).
- TEST_W, 16, width of the test_value debug tap (1..32).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  block can accept a request; high only in IDLE.
- req_we  in  1  1 = store, 0 = load.
- req_size  in  2  00 byte, 01 halfword, 10 word, 11 illegal.
- req_unsigned  in  1  load zero-extends when 1; ignored for stores and for word loads.
- req_addr  in  32  byte address.
- req_wdata  in  32  store data, right-justified (byte in [7:0], halfword in [15:0]).
- rsp_valid  out  1  one-cycle pulse: response valid.
- rsp_rdata  out  32  extended load data; 0 for stores and errors.
- rsp_err  out  1  qualified by rsp_valid: misaligned, illegal size, or out of range.
- test_value  out  TEST_W  combinational mem[0][TEST_W-1:0].

Behaviour:
- Reset (async, rst=1):
  - All DEPTH words are cleared to 0.
  - State is IDLE, the wait counter is 0, and captured request registers are cleared.
  - req_ready=1 once rst deasserts. rsp_valid=0, rsp_rdata=0, rsp_err=0.
- Reset mid-operation: the pending request is dropped, no write is committed, and no response is issued.
- States:
  - IDLE: req_ready=1. On req_valid at an edge, capture we/size/unsigned/addr/wdata, load cnt=LATENCY, go to BUSY.
  - BUSY: req_ready=0. If cnt!=0, decrement. If cnt==0, at that edge perform the access, register the response, pulse rsp_valid, and return to IDLE.
- Timing:
  - Accept at edge E0; access and rsp_valid assert after edge E(LATENCY+1), held for exactly one cycle.
  - req_ready is high again in the same cycle rsp_valid is high, so a new request may be accepted at the edge ending that cycle.
  - Peak throughput: one request per LATENCY+2 cycles.
- No response backpressure: the consumer must sample rsp_* during the rsp_valid cycle.
- Word index = addr[log2(DEPTH)+1:2]. Out of range = any addr bit above log2(DEPTH)+1 is set.
- Lanes are little-endian: addr[1:0]=0 selects bits [7:0], and addr[1:0]=3 selects bits [31:24].
- Error checks:
  - Halfword requires addr[0]=0.
  - Word requires addr[1:0]=0.
  - size=11 is always an error.
  - On error: no memory change, rsp_err=1, rsp_rdata=0.
- Stores: only the selected lanes are written; other bytes of the word keep their value. rsp_rdata=0, rsp_err=0.
- Loads:
  - Select the lane(s) by addr[1:0].
  - Byte and halfword loads sign-extend from bit 7 or bit 15 respectively, unless req_unsigned=1, in which case they zero-extend.
  - Word loads return the full word.
- req_* inputs are ignored while BUSY and need not be held stable after acceptance.
- test_value reflects a write to word 0 in the cycle after the committing edge.

Decomposition:
- Shared package dmem_pkg holds:
  - size encodings SZ_BYTE, SZ_HALF, SZ_WORD;
  - the state enum IDLE/BUSY;
  - the function computing 4-bit lane enables from size and addr[1:0].
- One combinational sub-module, dmem_load_align: inputs word, addr[1:0], size, unsigned; output extended 32-bit load data.

Test Plan:
- Reset checks, LATENCY=1:
  - Hold rst=1 for 2 cycles, then release → req_ready=1, rsp_valid=0, test_value=0, and a word load of addr 0x0 returns 0.
  - Assert rst=1 two cycles after accepting a word store of 0x12345678 to 0x8 → no rsp_valid pulse; a subsequent load of 0x8 returns 0x00000000.
- Word store then load:
  - Word store 0xDEADBEEF to 0x0 accepted at E0 → rsp_valid pulses after E2 with rsp_err=0, and test_value=0xBEEF from that cycle.
  - Word load of 0x0 then returns 0xDEADBEEF.
- Byte lanes:
  - After the word store above, byte-store 0x80 to 0x3 → word 0 becomes 0x80ADBEEF.
  - Signed byte load of 0x3 → 0xFFFFFF80; unsigned byte load → 0x00000080.
- Halfword:
  - Halfword-store 0xA5A5 to 0x6 → word 1 becomes 0xA5A50000.
  - Unsigned halfword load of 0x6 → 0x0000A5A5; signed → 0xFFFFA5A5.
- Errors:
  - Halfword load at 0x5, word store at 0x2, size=11 at 0x0, and word load at 4*DEPTH → each gives rsp_err=1 and rsp_rdata=0, with memory unchanged.
- Latency sweep and throughput:
  - Rerun at LATENCY=0 and LATENCY=7 → accept-to-rsp_valid gap of 1 and 8 edges respectively.
  - Holding req_valid=1 continuously yields one response every LATENCY+2 cycles.

Source files
------------

// File: rtl/dmem_bytelane_ctrl_pkg.sv
// dmem_pkg: shared definitions for the byte-lane data memory controller.
//   - size encodings for the req_size field
//   - controller state enum
//   - lane_mask(): 4-bit byte-lane enables from access size and addr[1:0]
package dmem_pkg;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    // Little-endian lanes: addr[1:0]=0 is bits [7:0]. Misaligned halfword and
    // word addresses are rejected before this mask is ever used for a write.
    function automatic logic [3:0] lane_mask(input logic [1:0] size,
                                             input logic [1:0] addr_lo);
        logic [3:0] m;
        case (size)
            SZ_BYTE: m = 4'b0001 << addr_lo;
            SZ_HALF: m = addr_lo[1] ? 4'b1100 : 4'b0011;
            SZ_WORD: m = 4'b1111;
            default: m = 4'b0000;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/dmem_load_align.sv
// dmem_load_align: combinational load extractor.
//   i_word     : full 32-bit word read from the array
//   i_addr_lo  : byte offset within the word
//   i_size     : access size (dmem_pkg SZ_*)
//   i_unsigned : 1 = zero-extend sub-word loads, 0 = sign-extend
//   o_data     : right-justified, extended load data (0 for illegal size)
module dmem_load_align
    import dmem_pkg::*;
(
    input  logic [31:0] i_word,
    input  logic [1:0]  i_addr_lo,
    input  logic [1:0]  i_size,
    input  logic        i_unsigned,
    output logic [31:0] o_data
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    always_comb begin
        w_byte = i_word[{i_addr_lo, 3'b000} +: 8];
        w_half = i_addr_lo[1] ? i_word[31:16] : i_word[15:0];
        case (i_size)
            SZ_BYTE: o_data = {{24{~i_unsigned & w_byte[7]}}, w_byte};
            SZ_HALF: o_data = {{16{~i_unsigned & w_half[15]}}, w_half};
            SZ_WORD: o_data = i_word;
            default: o_data = 32'h0;
        endcase
    end

endmodule

// File: rtl/dmem_bytelane_ctrl.sv
// dmem_bytelane_ctrl: DEPTH x 32-bit data memory with byte/halfword/word
// accesses, sign/zero-extending loads, alignment/range checking and a
// valid/ready request port with LATENCY wait states.
//   clk, rst            : clock (rising edge), async active-high reset
//   req_valid/req_ready : request handshake
//   req_we, req_size, req_unsigned, req_addr, req_wdata : request fields
//   rsp_valid           : one-cycle response pulse (no backpressure)
//   rsp_rdata, rsp_err  : response payload, qualified by rsp_valid
//   test_value          : mem[0][TEST_W-1:0], combinational debug tap
//
// Handshake: a request transfers on a rising edge where req_valid and
// req_ready are both high. req_ready is high exactly when the controller is
// IDLE; request fields are captured at that edge and need not be held. The
// response is presented for exactly one cycle with rsp_valid high, and the
// consumer must take it then.
module dmem_bytelane_ctrl
    import dmem_pkg::*;
#(
    parameter int DEPTH   = 256,
    parameter int LATENCY = 1,
    parameter int TEST_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [1:0]        req_size,
    input  logic              req_unsigned,
    input  logic [31:0]       req_addr,
    input  logic [31:0]       req_wdata,
    output logic              rsp_valid,
    output logic [31:0]       rsp_rdata,
    output logic              rsp_err,
    output logic [TEST_W-1:0] test_value
);

    localparam int AW = $clog2(DEPTH);

    logic [31:0] r_mem [DEPTH];
    state_t      r_state;
    logic [2:0]  r_cnt;
    logic        r_we;
    logic [1:0]  r_size;
    logic        r_uns;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic        r_rsp_valid;
    logic [31:0] r_rsp_rdata;
    logic        r_rsp_err;

    logic [AW-1:0] w_idx;
    logic          w_err;
    logic [3:0]    w_lanes;
    logic [31:0]   w_wlane;
    logic [31:0]   w_load;

    assign w_idx   = r_addr[AW+1:2];
    assign w_lanes = lane_mask(r_size, r_addr[1:0]);

    // Any address bit above the word index means the access is out of range.
    always_comb begin
        w_err = (r_size == 2'b11)
              | ((r_size == SZ_HALF) & r_addr[0])
              | ((r_size == SZ_WORD) & (|r_addr[1:0]))
              | (|r_addr[31:AW+2]);
    end

    // Replicate store data across all lanes; the lane mask picks the target.
    always_comb begin
        case (r_size)
            SZ_BYTE: w_wlane = {4{r_wdata[7:0]}};
            SZ_HALF: w_wlane = {2{r_wdata[15:0]}};
            default: w_wlane = r_wdata;
        endcase
    end

    dmem_load_align u_load_align (
        .i_word     (r_mem[w_idx]),
        .i_addr_lo  (r_addr[1:0]),
        .i_size     (r_size),
        .i_unsigned (r_uns),
        .o_data     (w_load)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= IDLE;
            r_cnt       <= 3'd0;
            r_we        <= 1'b0;
            r_size      <= 2'b00;
            r_uns       <= 1'b0;
            r_addr      <= 32'h0;
            r_wdata     <= 32'h0;
            r_rsp_valid <= 1'b0;
            r_rsp_rdata <= 32'h0;
            r_rsp_err   <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= 32'h0;
            end
        end else begin
            r_rsp_valid <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (req_valid) begin
                        r_we    <= req_we;
                        r_size  <= req_size;
                        r_uns   <= req_unsigned;
                        r_addr  <= req_addr;
                        r_wdata <= req_wdata;
                        r_cnt   <= 3'(LATENCY);
                        r_state <= BUSY;
                    end
                end
                BUSY: begin
                    if (r_cnt != 3'd0) begin
                        r_cnt <= r_cnt - 3'd1;
                    end else begin
                        r_rsp_valid <= 1'b1;
                        r_rsp_err   <= w_err;
                        r_rsp_rdata <= (w_err | r_we) ? 32'h0 : w_load;
                        if (r_we && !w_err) begin
                            for (int b = 0; b < 4; b++) begin
                                if (w_lanes[b]) begin
                                    r_mem[w_idx][8*b +: 8] <= w_wlane[8*b +: 8];
                                end
                            end
                        end
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign req_ready  = (r_state == IDLE);
    assign rsp_valid  = r_rsp_valid;
    assign rsp_rdata  = r_rsp_rdata;
    assign rsp_err    = r_rsp_err;
    assign test_value = r_mem[0][TEST_W-1:0];

endmodule

// File: tb/tb_dmem_bytelane_ctrl.sv
// Self-checking bench for dmem_bytelane_ctrl. Three instances share clk/rst:
// index 0 has LATENCY=1, index 1 LATENCY=0, index 2 LATENCY=7.
module tb_dmem_bytelane_ctrl;
    import dmem_pkg::*;

    localparam int NDUT = 3;

    logic        clk;
    logic        rst;
    logic        req_valid    [NDUT];
    logic        req_ready    [NDUT];
    logic        req_we       [NDUT];
    logic [1:0]  req_size     [NDUT];
    logic        req_unsigned [NDUT];
    logic [31:0] req_addr     [NDUT];
    logic [31:0] req_wdata    [NDUT];
    logic        rsp_valid    [NDUT];
    logic [31:0] rsp_rdata    [NDUT];
    logic        rsp_err      [NDUT];
    logic [15:0] test_value   [NDUT];

    logic [32:0] exp_q[$];          // {err, rdata}
    logic [31:0] mdl [NDUT][256];
    int          n_checks;
    int          n_fail;
    int          last_gap;

    for (genvar g = 0; g < NDUT; g++) begin : g_dut
        dmem_bytelane_ctrl #(
            .DEPTH   (256),
            .LATENCY ((g == 0) ? 1 : ((g == 1) ? 0 : 7)),
            .TEST_W  (16)
        ) u_dut (
            .clk          (clk),
            .rst          (rst),
            .req_valid    (req_valid[g]),
            .req_ready    (req_ready[g]),
            .req_we       (req_we[g]),
            .req_size     (req_size[g]),
            .req_unsigned (req_unsigned[g]),
            .req_addr     (req_addr[g]),
            .req_wdata    (req_wdata[g]),
            .rsp_valid    (rsp_valid[g]),
            .rsp_rdata    (rsp_rdata[g]),
            .rsp_err      (rsp_err[g]),
            .test_value   (test_value[g])
        );
    end

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int lat_of(input int d);
        return (d == 0) ? 1 : ((d == 1) ? 0 : 7);
    endfunction

    function automatic void model_clear();
        for (int d = 0; d < NDUT; d++)
            for (int i = 0; i < 256; i++)
                mdl[d][i] = 32'h0;
    endfunction

    // Reference behaviour: returns {err, rdata} and applies stores.
    function automatic logic [32:0] model_access(input int d, input logic we,
            input logic [1:0] size, input logic uns, input logic [31:0] addr,
            input logic [31:0] wdata);
        logic [31:0] w, m, sh;
        logic [4:0]  sa;
        int          idx;
        if (size == 2'b11 || (size == 2'b01 && addr[0]) ||
            (size == 2'b10 && addr[1:0] != 2'b00) || addr >= 32'd1024)
            return {1'b1, 32'h0};
        idx = int'(addr[9:2]);
        sa  = {addr[1:0], 3'b000};
        w   = mdl[d][idx];
        m   = (size == 2'b00) ? 32'hFF : ((size == 2'b01) ? 32'hFFFF : 32'hFFFF_FFFF);
        if (we) begin
            mdl[d][idx] = (w & ~(m << sa)) | ((wdata & m) << sa);
            return {1'b0, 32'h0};
        end
        sh = (w >> sa) & m;
        if (!uns && size == 2'b00 && sh[7])  sh = sh | 32'hFFFF_FF00;
        if (!uns && size == 2'b01 && sh[15]) sh = sh | 32'hFFFF_0000;
        return {1'b0, sh};
    endfunction

    // ---------------- driver ----------------
    // Starts and ends at a falling edge. Pushes the expectation on acceptance,
    // scrambles the request bus while busy, pops when rsp_valid appears.
    task automatic do_req(input int d, input logic we, input logic [1:0] size,
            input logic uns, input logic [31:0] addr, input logic [31:0] wdata,
            input logic [32:0] exp, input string name);
        logic [32:0] e;
        int n;
        last_gap = -1;
        req_valid[d] = 1'b1; req_we[d] = we; req_size[d] = size;
        req_unsigned[d] = uns; req_addr[d] = addr; req_wdata[d] = wdata;
        n = 0;
        while (!req_ready[d] && n < 20) begin @(negedge clk); n++; end
        exp_q.push_back(exp);
        @(posedge clk);
        @(negedge clk);
        // Garbage store to word 0 while busy; must be ignored.
        req_we[d] = 1'b1; req_size[d] = SZ_WORD; req_addr[d] = 32'h0;
        req_wdata[d] = $urandom; req_unsigned[d] = 1'b0;
        n = 0;
        do begin
            @(posedge clk); n++; @(negedge clk);
        end while (!rsp_valid[d] && n < 20);
        req_valid[d] = 1'b0;
        n_checks++;
        if (!rsp_valid[d]) begin
            n_fail++;
            e = exp_q.pop_front();
            $display("FAIL %s: no rsp_valid within 20 edges, expected err=%0b rdata=%08h",
                     name, e[32], e[31:0]);
        end else begin
            e = exp_q.pop_front();
            last_gap = n;
            if ({rsp_err[d], rsp_rdata[d]} !== e) begin
                n_fail++;
                $display("FAIL %s: got err=%0b rdata=%08h, expected err=%0b rdata=%08h",
                         name, rsp_err[d], rsp_rdata[d], e[32], e[31:0]);
            end
        end
    endtask

    task automatic req_chk(input int d, input logic we, input logic [1:0] size,
            input logic uns, input logic [31:0] addr, input logic [31:0] wdata,
            input logic exp_err, input logic [31:0] exp_rdata, input string name);
        void'(model_access(d, we, size, uns, addr, wdata));
        do_req(d, we, size, uns, addr, wdata, {exp_err, exp_rdata}, name);
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        model_clear();
        @(negedge clk);
        n_checks++;
        if (req_ready[0] !== 1'b1 || rsp_valid[0] !== 1'b0 || test_value[0] !== 16'h0 ||
            rsp_rdata[0] !== 32'h0 || rsp_err[0] !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_outputs: got ready=%0b valid=%0b tv=%04h rdata=%08h err=%0b, expected 1 0 0000 00000000 0",
                     req_ready[0], rsp_valid[0], test_value[0], rsp_rdata[0], rsp_err[0]);
        end
        req_chk(0, 1'b0, SZ_WORD, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0, "reset_load0");
    endtask

    task automatic test_reset_mid_op();
        logic seen;
        req_valid[0] = 1'b1; req_we[0] = 1'b1; req_size[0] = SZ_WORD;
        req_unsigned[0] = 1'b0; req_addr[0] = 32'h8; req_wdata[0] = 32'h1234_5678;
        @(posedge clk);              // accept
        @(negedge clk);
        req_valid[0] = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        seen = 1'b0;
        repeat (2) begin @(negedge clk); seen = seen | rsp_valid[0]; end
        rst = 1'b0;
        model_clear();
        repeat (3) begin @(negedge clk); seen = seen | rsp_valid[0]; end
        n_checks++;
        if (seen !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_mid_op_rsp: got rsp_valid pulse=%0b, expected 0", seen);
        end
        req_chk(0, 1'b0, SZ_WORD, 1'b0, 32'h8, 32'h0, 1'b0, 32'h0, "reset_mid_op_load8");
    endtask

    task automatic test_word();
        req_chk(0, 1'b1, SZ_WORD, 1'b0, 32'h0, 32'hDEAD_BEEF, 1'b0, 32'h0, "word_store");
        n_checks++;
        if (last_gap !== 2) begin
            n_fail++;
            $display("FAIL word_store_gap: got %0d edges, expected 2", last_gap);
        end
        n_checks++;
        if (test_value[0] !== 16'hBEEF) begin
            n_fail++;
            $display("FAIL test_value: got %04h, expected beef", test_value[0]);
        end
        req_chk(0, 1'b0, SZ_WORD, 1'b0, 32'h0, 32'h0, 1'b0, 32'hDEAD_BEEF, "word_load");
    endtask

    task automatic test_byte_lanes();
        req_chk(0, 1'b1, SZ_BYTE, 1'b0, 32'h3, 32'hFFFF_FF80, 1'b0, 32'h0,          "byte_store3");
        req_chk(0, 1'b0, SZ_WORD, 1'b0, 32'h0, 32'h0,         1'b0, 32'h80AD_BEEF,  "byte_word0");
        req_chk(0, 1'b0, SZ_BYTE, 1'b0, 32'h3, 32'h0,         1'b0, 32'hFFFF_FF80,  "byte_load3_s");
        req_chk(0, 1'b0, SZ_BYTE, 1'b1, 32'h3, 32'h0,         1'b0, 32'h0000_0080,  "byte_load3_u");
        req_chk(0, 1'b0, SZ_BYTE, 1'b0, 32'h1, 32'h0,         1'b0, 32'hFFFF_FFBE,  "byte_load1_s");
        req_chk(0, 1'b0, SZ_BYTE, 1'b0, 32'h2, 32'h0,         1'b0, 32'hFFFF_FFAD,  "byte_load2_s");
    endtask

    task automatic test_halfword();
        req_chk(0, 1'b1, SZ_HALF, 1'b0, 32'h6, 32'h1234_A5A5, 1'b0, 32'h0,          "half_store6");
        req_chk(0, 1'b0, SZ_WORD, 1'b0, 32'h4, 32'h0,         1'b0, 32'hA5A5_0000,  "half_word1");
        req_chk(0, 1'b0, SZ_HALF, 1'b1, 32'h6, 32'h0,         1'b0, 32'h0000_A5A5,  "half_load6_u");
        req_chk(0, 1'b0, SZ_HALF, 1'b0, 32'h6, 32'h0,         1'b0, 32'hFFFF_A5A5,  "half_load6_s");
    endtask

    task automatic test_errors();
        req_chk(0, 1'b0, SZ_HALF, 1'b0, 32'h5,   32'h0,         1'b1, 32'h0, "err_half5");
        req_chk(0, 1'b1, SZ_WORD, 1'b0, 32'h2,   32'hFFFF_FFFF, 1'b1, 32'h0, "err_word2");
        req_chk(0, 1'b1, 2'b11,   1'b0, 32'h0,   32'h5555_5555, 1'b1, 32'h0, "err_size11");
        req_chk(0, 1'b0, SZ_WORD, 1'b0, 32'h400, 32'h0,         1'b1, 32'h0, "err_range");
        req_chk(0, 1'b0, SZ_WORD, 1'b0, 32'h0,   32'h0, 1'b0, 32'h80AD_BEEF, "err_keep0");
        req_chk(0, 1'b0, SZ_WORD, 1'b0, 32'h4,   32'h0, 1'b0, 32'hA5A5_0000, "err_keep1");
    endtask

    task automatic test_latency(input int d);
        logic [31:0] v;
        v = $urandom;
        req_chk(d, 1'b1, SZ_WORD, 1'b0, 32'h20, v, 1'b0, 32'h0, "lat_store");
        n_checks++;
        if (last_gap !== lat_of(d) + 1) begin
            n_fail++;
            $display("FAIL latency_gap[%0d]: got %0d edges, expected %0d", d, last_gap, lat_of(d) + 1);
        end
        req_chk(d, 1'b0, SZ_WORD, 1'b0, 32'h20, 32'h0, 1'b0, v, "lat_load");
    endtask

    task automatic test_back_to_back(input int d);
        logic [32:0] e, exp;
        int nrsp, last, edge_n;
        exp = model_access(d, 1'b0, SZ_WORD, 1'b0, 32'h20, 32'h0);
        req_valid[d] = 1'b1; req_we[d] = 1'b0; req_size[d] = SZ_WORD;
        req_unsigned[d] = 1'b0; req_addr[d] = 32'h20; req_wdata[d] = 32'h0;
        if (req_ready[d]) exp_q.push_back(exp);
        nrsp = 0; last = -1; edge_n = 0;
        while (nrsp < 4 && edge_n < 100) begin
            @(posedge clk); edge_n++; @(negedge clk);
            if (rsp_valid[d]) begin
                n_checks++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL b2b_extra[%0d]: got unexpected response rdata=%08h, expected none",
                             d, rsp_rdata[d]);
                end else begin
                    e = exp_q.pop_front();
                    if ({rsp_err[d], rsp_rdata[d]} !== e) begin
                        n_fail++;
                        $display("FAIL b2b_data[%0d]: got err=%0b rdata=%08h, expected err=%0b rdata=%08h",
                                 d, rsp_err[d], rsp_rdata[d], e[32], e[31:0]);
                    end
                end
                if (last >= 0) begin
                    n_checks++;
                    if (edge_n - last !== lat_of(d) + 2) begin
                        n_fail++;
                        $display("FAIL b2b_period[%0d]: got %0d cycles, expected %0d",
                                 d, edge_n - last, lat_of(d) + 2);
                    end
                end
                last = edge_n;
                nrsp++;
                if (nrsp == 4) req_valid[d] = 1'b0;
            end
            if (req_valid[d] && req_ready[d]) exp_q.push_back(exp);
        end
        req_valid[d] = 1'b0;
        n_checks++;
        if (nrsp != 4 || exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL b2b_count[%0d]: got %0d responses with %0d pending, expected 4 with 0 pending",
                     d, nrsp, exp_q.size());
        end
        exp_q.delete();
        repeat (10) @(negedge clk);
    endtask

    task automatic test_random(input int d);
        logic        we, uns;
        logic [1:0]  size;
        logic [31:0] addr, wdata;
        for (int i = 0; i < 40; i++) begin
            we    = 1'($urandom_range(0, 1));
            uns   = 1'($urandom_range(0, 1));
            size  = 2'($urandom_range(0, 3));
            addr  = 32'($urandom_range(0, 63));
            if ($urandom_range(0, 9) == 0) addr = addr + 32'h400;
            wdata = $urandom;
            do_req(d, we, size, uns, addr, wdata,
                   model_access(d, we, size, uns, addr, wdata), "random");
        end
    endtask

    // ---------------- sequence / report ----------------
    initial begin
        n_checks = 0;
        n_fail   = 0;
        last_gap = -1;
        rst      = 1'b1;
        for (int d = 0; d < NDUT; d++) begin
            req_valid[d] = 1'b0; req_we[d] = 1'b0; req_size[d] = 2'b00;
            req_unsigned[d] = 1'b0; req_addr[d] = 32'h0; req_wdata[d] = 32'h0;
        end
        model_clear();
        @(negedge clk);

        test_reset();
        test_reset_mid_op();
        test_word();
        test_byte_lanes();
        test_halfword();
        test_errors();
        for (int d = 0; d < NDUT; d++) test_latency(d);
        for (int d = 0; d < NDUT; d++) test_back_to_back(d);
        test_random(0);
        test_random(2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
